serial_adder8: RTL and testbench
================================

# serial_adder8

Bit-serial 8-bit two's-complement adder for the RISC-V ALU datapath, and the additive counterpart of the existing combinational subtractor. It latches two operands on a start handshake, then resolves one bit per clock through a single 1-bit full adder, LSB first. It reports sum, unsigned carry-out and signed overflow with a one-cycle done pulse. It is the low-area option for multi-cycle ALU operations.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  a + b mod 2^WIDTH
- carryout  output  1  unsigned carry out of MSB
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB)

## Operation
- Reset (asynchronous, active-high):
  - state = IDLE
  - sum = 0, carryout = 0, overflow = 0, busy = 0, done = 0
  - internal shift registers, carry flop and bit counter cleared
- State machine:
  - IDLE: start=1 captures a and b, clears the carry flop and counter, goes to SHIFT. start=0 stays in IDLE.
  - SHIFT: each cycle adds bit[count] of A, B and the carry flop. The sum bit shifts into the result register from the MSB end. The carry flop is updated. The carry into the MSB is recorded when count = WIDTH-1. After bit WIDTH-1, go to DONE. start is ignored here.
  - DONE: done=1 for this cycle only. Next state is SHIFT if start=1 (new operands captured), otherwise IDLE.
- Outputs:
  - sum, carryout and overflow update only on the edge entering DONE.
  - They hold until the next entry to DONE or reset.
  - They are never partially updated while busy.
- Arithmetic is modulo 2^WIDTH.
  - carryout = bit WIDTH of the unsigned sum.
  - overflow = c_in(MSB) XOR c_out(MSB).
- Input changes on a and b outside the capture edge have no effect.

## Timing
- Start accepted at edge E:
  - busy is high from E through edge E+WIDTH.
  - done is high for the cycle after edge E+WIDTH, so latency = WIDTH+1 edges.
  - Back-to-back start in DONE gives a throughput of one result per WIDTH+1 cycles.
- Reset asserted mid-operation aborts immediately. No done pulse is produced and prior results are zeroed.
- Reset deasserted with start=1 has no effect until the first clock edge.

## Configuration
- SERIAL_ADDER8_SUB_EN, when defined:
  - Adds input port `sub` (1 bit), captured with the operands.
  - sub=1 complements B during SHIFT and initialises the carry flop to 1, so sum = a − b.
  - carryout then reports borrow, i.e. the inverted final carry.
  - overflow then flags positive−negative=negative and negative−positive=positive.
- Without the macro: no `sub` port, add only, carry flop initialised to 0.

## Structure
- Package serial_adder8_pkg holds:
  - state enum: IDLE, SHIFT, DONE
  - default WIDTH constant
  - counter width constant: $clog2(WIDTH)
- One sub-module, fulladder (a, b, cin → s, cout), instantiated once for the per-bit datapath.

## Test plan
- a=7, b=3 → after WIDTH+1 edges: sum=10, carryout=0, overflow=0, done pulses exactly one cycle.
- a=100, b=100 → sum=200, carryout=0, overflow=1. a=255, b=1 → sum=0, carryout=1, overflow=0. a=128, b=255 → sum=127, carryout=1, overflow=1.
- Busy interference:
  - Stimulus: a=7, b=3 running; at cycle 3 of SHIFT, start=1 with a=1, b=1.
  - Response: the pulse is ignored and the result is 10.
  - Then start held high in the DONE cycle with a=1, b=1 → the next result is 2 after WIDTH+1 more edges.
- Reset mid-operation:
  - Stimulus: rst pulsed during SHIFT.
  - Response: busy=0, sum=0 asynchronously, no done pulse.
  - A fresh a=38, b=8 then yields 46.
- With SERIAL_ADDER8_SUB_EN, sub=1:
  - 8−38 → 226, carryout(borrow)=1, overflow=0.
  - 5−(−127) → 132, overflow=1.
  - (−127)−5 → 124, overflow=1.
  - 7−3 → 4, borrow=0.

Source files
------------

// File: rtl/serial_adder8_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder8_pkg
// Shared types and constants for the bit-serial adder.
//   state_e         : controller states (IDLE, SHIFT, DONE)
//   SA_WIDTH_DEF    : default operand/result width
//   SA_CNT_W_DEF    : bit-counter width for the default operand width
// Optional feature macro used by the adder: SERIAL_ADDER8_SUB_EN
// -----------------------------------------------------------------------------
package serial_adder8_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int SA_WIDTH_DEF = 8;
   localparam int SA_CNT_W_DEF = $clog2(SA_WIDTH_DEF);

endpackage : serial_adder8_pkg

// File: rtl/serial_adder8_fulladder.sv
// -----------------------------------------------------------------------------
// fulladder
// One-bit full adder forming the per-bit datapath of the serial adder.
//   a, b  : input  addend bits
//   cin   : input  carry in
//   s     : output sum bit
//   cout  : output carry out
// -----------------------------------------------------------------------------
module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule : fulladder

// File: rtl/serial_adder8.sv
// -----------------------------------------------------------------------------
// serial_adder8
// Bit-serial two's-complement adder. Operands are captured on an accepted
// start, then resolved LSB first through one full adder, one bit per clock.
// Results (sum, carryout, overflow) update only on the edge entering DONE,
// when done pulses for one cycle.
//   clk       : input  rising-edge clock
//   rst       : input  asynchronous active-high reset
//   start     : input  request, sampled in IDLE or DONE only
//   sub       : input  subtract select (only with SERIAL_ADDER8_SUB_EN)
//   a, b      : input  WIDTH-bit operands, captured with start
//   busy      : output high while bits are being resolved
//   done      : output one-cycle result-valid pulse
//   sum       : output WIDTH-bit result (mod 2^WIDTH)
//   carryout  : output carry out of MSB (borrow when subtracting)
//   overflow  : output signed overflow
// Configuration macro: SERIAL_ADDER8_SUB_EN adds the sub port and a - b.
// -----------------------------------------------------------------------------
module serial_adder8
   import serial_adder8_pkg::*;
#(
   parameter int WIDTH = SA_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SERIAL_ADDER8_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carryout,
   output logic             overflow
);

   localparam int             CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               sub_q, sub_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               sub_in_s;
   logic               fa_b_s;
   logic               fa_s_s;
   logic               fa_cout_s;

`ifdef SERIAL_ADDER8_SUB_EN
   assign sub_in_s = sub;
`else
   assign sub_in_s = 1'b0;
`endif

   // Subtraction is a + ~b + 1: invert each B bit, the +1 comes from the carry seed.
   assign fa_b_s = b_q[0] ^ sub_q;

   fulladder u_fa (
      .a    (a_q[0]),
      .b    (fa_b_s),
      .cin  (carry_q),
      .s    (fa_s_s),
      .cout (fa_cout_s)
   );

   // Next-state and datapath computation for the controller.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      sub_d   = sub_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               sub_d   = sub_in_s;
               carry_d = sub_in_s;
               cnt_d   = '0;
               res_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_SHIFT;
            end else begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            res_d   = {fa_s_s, res_q[WIDTH-1:1]};
            carry_d = fa_cout_s;
            if (cnt_q == CNT_LAST) begin
               // carry_q is the carry into the MSB at this point.
               sum_d   = {fa_s_s, res_q[WIDTH-1:1]};
               cout_d  = fa_cout_s ^ sub_q;
               ovf_d   = carry_q ^ fa_cout_s;
               cnt_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
               busy_d  = 1'b1;
               state_d = ST_SHIFT;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, datapath and registered-output flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         sub_q   <= sub_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign carryout = cout_q;
   assign overflow = ovf_q;

endmodule : serial_adder8

// File: tb/tb_serial_adder8.sv
// -----------------------------------------------------------------------------
// tb_serial_adder8
// Self-checking bench for serial_adder8: directed cases, busy interference,
// mid-operation reset and randomized operations against an arithmetic model.
// Honours SERIAL_ADDER8_SUB_EN for the subtract cases.
// -----------------------------------------------------------------------------
module tb_serial_adder8;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
`ifdef SERIAL_ADDER8_SUB_EN
   logic         sub;
`endif
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         carryout;
   logic         overflow;

   int           checks;
   int           errors;
   logic [W-1:0] last_sum;

   serial_adder8 #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
`ifdef SERIAL_ADDER8_SUB_EN
      .sub      (sub),
`endif
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .carryout (carryout),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic, returns {overflow, carryout, sum}.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
      int ux, uy, ur, sx, sy, sr;
      logic co, ov;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (s) begin
         ur = ux - uy;
         sr = sx - sy;
         co = (ux < uy);
      end else begin
         ur = ux + uy;
         sr = sx + sy;
         co = (ur > 255);
      end
      ov = (sr > 127) || (sr < -128);
      model = {ov, co, ur[W-1:0]};
   endfunction

   // Called at a negedge (or just after): launches an op, checks cycle-exact
   // timing and results, returns at the negedge of the DONE cycle.
   // glitch_at > 0 pulses start with a=1,b=1 at that SHIFT negedge.
   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                         input int glitch_at);
      logic [W+1:0] exp;
      exp   = model(ia, ib, isub);
      start = 1'b1;
      a     = ia;
      b     = ib;
`ifdef SERIAL_ADDER8_SUB_EN
      sub   = isub;
`endif
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      check("busy_after_start", {31'd0, busy}, 32'd1);
      check("sum_hold_busy", {24'd0, sum}, {24'd0, last_sum});
      for (int i = 1; i < W; i++) begin
         if (i == glitch_at) begin
            start = 1'b1;
            a     = 8'd1;
            b     = 8'd1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         check("busy_shift", {31'd0, busy}, 32'd1);
         check("done_early", {31'd0, done}, 32'd0);
      end
      start = 1'b0;
      @(negedge clk);
      check("done_pulse", {31'd0, done}, 32'd1);
      check("busy_done", {31'd0, busy}, 32'd0);
      check("sum", {24'd0, sum}, {24'd0, exp[W-1:0]});
      check("carryout", {31'd0, carryout}, {31'd0, exp[W]});
      check("overflow", {31'd0, overflow}, {31'd0, exp[W+1]});
      last_sum = exp[W-1:0];
   endtask

   // Leave DONE with start low and confirm the pulse lasted one cycle.
   task automatic go_idle();
      start = 1'b0;
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("busy_idle", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rs;
      checks   = 0;
      errors   = 0;
      last_sum = '0;
      rst      = 1'b1;
      start    = 1'b0;
      a        = '0;
      b        = '0;
`ifdef SERIAL_ADDER8_SUB_EN
      sub      = 1'b0;
`endif
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sum", {24'd0, sum}, 32'd0);
      check("rst_carry", {31'd0, carryout}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);

      // start held high across reset release takes effect only at the next edge
      start = 1'b1;
      a     = 8'd7;
      b     = 8'd3;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rel_busy", {31'd0, busy}, 32'd0);
      run_op(8'd7, 8'd3, 1'b0, 0);
      go_idle();

      run_op(8'd100, 8'd100, 1'b0, 0);
      go_idle();
      run_op(8'd255, 8'd1, 1'b0, 0);
      go_idle();
      run_op(8'd128, 8'd255, 1'b0, 0);
      go_idle();

      // busy interference, then back-to-back start from DONE
      run_op(8'd7, 8'd3, 1'b0, 2);
      run_op(8'd1, 8'd1, 1'b0, 0);
      go_idle();

      // mid-operation reset
      run_op(8'd100, 8'd100, 1'b0, 0);
      start = 1'b1;
      a     = 8'd9;
      b     = 8'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_sum", {24'd0, sum}, 32'd0);
      check("mid_rst_carry", {31'd0, carryout}, 32'd0);
      check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      rst      = 1'b0;
      last_sum = '0;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clk);
         check("mid_rst_no_done", {31'd0, done}, 32'd0);
      end
      run_op(8'd38, 8'd8, 1'b0, 0);
      go_idle();

`ifdef SERIAL_ADDER8_SUB_EN
      run_op(8'd8, 8'd38, 1'b1, 0);
      go_idle();
      run_op(8'd5, 8'h81, 1'b1, 0);
      go_idle();
      run_op(8'h81, 8'd5, 1'b1, 0);
      go_idle();
      run_op(8'd7, 8'd3, 1'b1, 0);
      go_idle();
`endif

      // randomized operations, mixing back-to-back and idle gaps
      for (int n = 0; n < 40; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
`ifdef SERIAL_ADDER8_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         run_op(ra, rb, rs, 0);
         if ($urandom_range(1, 0) == 1) begin
            go_idle();
         end else begin
            start = 1'b0;
         end
      end
      go_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_serial_adder8
